// File: rtl/sipo_pkg.sv
// Shared defaults and helpers for the serial-in/parallel-out receive stage.
package sipo_pkg;

  localparam int N_DEF         = 4;
  localparam bit MSB_FIRST_DEF = 1'b1;

  // Bit-counter width; never below one bit so the counter always exists.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_deserializer_out_hold_reg.sv
// One-entry valid/ready holding register; flags words that arrive while the
// held word is stalled.
module out_hold_reg #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_ready,
  input  logic         i_ovr_clr,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [N-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;
  logic         w_xfer;
  logic         w_accept;
  logic         w_drop;

  assign w_xfer   = r_valid && i_ready;
  assign w_accept = i_load && (!r_valid || i_ready);
  assign w_drop   = i_load && r_valid && !i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= i_load_data;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      // A drop on the same edge as a clear must still be reported.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: shifts in one bit per strobe and hands each
// completed word to a one-entry output holding register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_si,
  input  logic         i_si_valid,
  input  logic         i_frame_clr,
  output logic [N-1:0] o_dout,
  output logic         o_dout_valid,
  input  logic         i_dout_ready,
  output logic         o_busy,
  output logic         o_overrun,
  input  logic         i_overrun_clr
);

  localparam int CW = cnt_w(N);

  logic [N-1:0]  r_shift_reg;
  logic [CW-1:0] r_bit_cnt;
  logic          r_busy;
  logic [N-1:0]  w_shift_next;
  logic          w_last_bit;
  logic          w_complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift_reg[N-2:0], i_si};
    end else begin : g_lsb_first
      assign w_shift_next = {i_si, r_shift_reg[N-1:1]};
    end
  endgenerate

  assign w_last_bit = (r_bit_cnt == CW'(N - 1));
  // frame_clr cancels a completion on the same edge.
  assign w_complete = i_si_valid && w_last_bit && !i_frame_clr;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_frame_clr) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_busy      <= 1'b0;
    end else if (i_si_valid) begin
      r_shift_reg <= w_shift_next;
      r_bit_cnt   <= w_last_bit ? '0 : r_bit_cnt + CW'(1);
      r_busy      <= !w_last_bit;
    end
  end

  out_hold_reg #(.N(N)) u_out_hold_reg (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_complete),
    .i_load_data (w_shift_next),
    .i_ready     (i_dout_ready),
    .i_ovr_clr   (i_overrun_clr),
    .o_data      (o_dout),
    .o_valid     (o_dout_valid),
    .o_overrun   (o_overrun)
  );

  assign o_busy = r_busy;

endmodule
